// File: rtl/rf_arb_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package rf_arb_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int XLEN       = 32;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_PEND  = 2'd1,
      ST_FORCE = 2'd2
   } arb_state_e;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] addr;
      logic [XLEN-1:0]       data;
   } fir_entry_t;

   // x0 is hardwired zero, so a zero source never depends on a queued write.
   function automatic logic addr_hit(input logic [REG_ADDR_W-1:0] addr,
                                     input logic [REG_ADDR_W-1:0] rs1,
                                     input logic [REG_ADDR_W-1:0] rs2);
      return ((addr == rs1) && (rs1 != '0)) || ((addr == rs2) && (rs2 != '0));
   endfunction

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Signal bundle between writeback, FIR engine, decode and the register-file write port.
interface rf_wb_arbiter_if #(
   parameter int DEPTH = 4
);
   import rf_arb_pkg::*;

   localparam int CW = $clog2(DEPTH) + 1;

   logic                  fir_valid;
   logic                  fir_ready;
   logic [REG_ADDR_W-1:0] fir_waddr;
   logic [XLEN-1:0]       fir_wdata;
   logic                  core_we;
   logic [REG_ADDR_W-1:0] core_rd;
   logic [XLEN-1:0]       core_wdata;
   logic                  core_stall;
   logic [REG_ADDR_W-1:0] rs1;
   logic [REG_ADDR_W-1:0] rs2;
   logic                  raw_hazard;
   logic                  rf_we;
   logic [REG_ADDR_W-1:0] rf_waddr;
   logic [XLEN-1:0]       rf_wdata;
   logic [CW-1:0]         fifo_count;

   modport master (
      output fir_valid, fir_waddr, fir_wdata, core_we, core_rd, core_wdata, rs1, rs2,
      input  fir_ready, core_stall, raw_hazard, rf_we, rf_waddr, rf_wdata, fifo_count
   );

   modport slave (
      input  fir_valid, fir_waddr, fir_wdata, core_we, core_rd, core_wdata, rs1, rs2,
      output fir_ready, core_stall, raw_hazard, rf_we, rf_waddr, rf_wdata, fifo_count
   );

endinterface

// File: rtl/rf_wr_fifo.sv
// Synchronous FIR write FIFO; exposes every slot's address and validity for hazard checks.
module rf_wr_fifo
   import rf_arb_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int PW = $clog2(DEPTH),
   localparam int CW = PW + 1
) (
   input  logic                                 clock,
   input  logic                                 reset,
   input  logic                                 push_i,
   input  fir_entry_t                           push_data_i,
   input  logic                                 pop_i,
   output fir_entry_t                           head_o,
   output logic [CW-1:0]                        count_o,
   output logic [DEPTH-1:0]                     entry_valid_o,
   output logic [DEPTH-1:0][REG_ADDR_W-1:0]     entry_addr_o
);

   fir_entry_t     mem_q [DEPTH];
   logic [PW-1:0]  wr_ptr_q;
   logic [PW-1:0]  rd_ptr_q;
   logic [CW-1:0]  count_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop_i)  rd_ptr_q <= rd_ptr_q + PW'(1);
         case ({push_i, pop_i})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage needs no reset: stale slots are masked by entry_valid_o.
   always_ff @(posedge clock) begin
      if (push_i) mem_q[wr_ptr_q] <= push_data_i;
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_tap
         logic [PW-1:0] offs;
         assign offs              = PW'(gi) - rd_ptr_q;
         assign entry_valid_o[gi] = ({1'b0, offs} < count_q);
         assign entry_addr_o[gi]  = mem_q[gi].addr;
      end
   endgenerate

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: core writeback first, queued FIR writes with bounded starvation.
module rf_wb_arbiter
   import rf_arb_pkg::*;
#(
   parameter int DEPTH    = 4,
   parameter int MAX_WAIT = 8
) (
   input logic            clock,
   input logic            reset,
   rf_wb_arbiter_if.slave bus
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int WW = $clog2(MAX_WAIT + 1);

   arb_state_e                        state_q, state_d;
   logic [WW-1:0]                     wait_cnt_q, wait_cnt_d;
   logic [CW-1:0]                     count;
   fir_entry_t                        head;
   fir_entry_t                        push_data;
   logic                              push, pop, last_out, core_wr, fir_ready;
   logic [DEPTH-1:0]                  entry_valid;
   logic [DEPTH-1:0][REG_ADDR_W-1:0]  entry_addr;
   logic [DEPTH-1:0]                  hit;
   logic                              rf_we;
   logic [REG_ADDR_W-1:0]             rf_waddr;
   logic [XLEN-1:0]                   rf_wdata;
   logic                              core_stall;

   // Full is judged on the registered count, so a same-cycle dequeue does not reopen the FIFO.
   assign fir_ready = (count < CW'(DEPTH));
   assign push      = bus.fir_valid && fir_ready && (bus.fir_waddr != '0);
   assign push_data = '{addr: bus.fir_waddr, data: bus.fir_wdata};
   assign core_wr   = bus.core_we && (bus.core_rd != '0);
   assign last_out  = pop && !push && (count == CW'(1));

   rf_wr_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clock         (clock),
      .reset         (reset),
      .push_i        (push),
      .push_data_i   (push_data),
      .pop_i         (pop),
      .head_o        (head),
      .count_o       (count),
      .entry_valid_o (entry_valid),
      .entry_addr_o  (entry_addr)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= ST_EMPTY;
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   always_comb begin
      wait_cnt_d = wait_cnt_q;
      if (pop || (count == '0))
         wait_cnt_d = '0;
      else if (wait_cnt_q != WW'(MAX_WAIT))
         wait_cnt_d = wait_cnt_q + WW'(1);

      state_d = state_q;
      case (state_q)
         ST_EMPTY: if (push) state_d = ST_PEND;
         ST_PEND: begin
            if (last_out)
               state_d = ST_EMPTY;
            else if (wait_cnt_d == WW'(MAX_WAIT))
               state_d = ST_FORCE;
         end
         ST_FORCE: state_d = last_out ? ST_EMPTY : ST_PEND;
         default:  state_d = ST_EMPTY;
      endcase
   end

   always_comb begin
      rf_we      = 1'b0;
      rf_waddr   = '0;
      rf_wdata   = '0;
      core_stall = 1'b0;
      pop        = 1'b0;
      if (state_q == ST_FORCE) begin
         rf_we      = 1'b1;
         rf_waddr   = head.addr;
         rf_wdata   = head.data;
         core_stall = 1'b1;
         pop        = 1'b1;
      end else if (core_wr) begin
         rf_we    = 1'b1;
         rf_waddr = bus.core_rd;
         rf_wdata = bus.core_wdata;
      end else if (count != '0) begin
         rf_we    = 1'b1;
         rf_waddr = head.addr;
         rf_wdata = head.data;
         pop      = 1'b1;
      end
   end

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_haz
         assign hit[gi] = entry_valid[gi] && addr_hit(entry_addr[gi], bus.rs1, bus.rs2);
      end
   endgenerate

   assign bus.raw_hazard = |hit;
   assign bus.fir_ready  = fir_ready;
   assign bus.core_stall = core_stall;
   assign bus.rf_we      = rf_we;
   assign bus.rf_waddr   = rf_waddr;
   assign bus.rf_wdata   = rf_wdata;
   assign bus.fifo_count = count;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: per-cycle vector table plus starvation and reset sequences.
module tb_rf_wb_arbiter;
   import rf_arb_pkg::*;

   localparam int DEPTH    = 4;
   localparam int MAX_WAIT = 8;

   typedef struct {
      logic        fv;
      logic [4:0]  fa;
      logic [31:0] fd;
      logic        cw;
      logic [4:0]  cr;
      logic [31:0] cd;
      logic [4:0]  r1;
      logic [4:0]  r2;
      logic        e_rdy;
      logic        e_stall;
      logic        e_haz;
      logic        e_we;
      logic [4:0]  e_addr;
      logic [31:0] e_data;
      logic [2:0]  e_cnt;
   } vec_t;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;
   vec_t vecs[$];

   always #5 clock = ~clock;

   rf_wb_arbiter_if #(.DEPTH(DEPTH)) bus ();

   rf_wb_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s[%0d]: got %0h, expected %0h", nm, idx, act, exp);
      end
   endtask

   task automatic drive(input logic fv, input logic [4:0] fa, input logic [31:0] fd,
                        input logic cw, input logic [4:0] cr, input logic [31:0] cd,
                        input logic [4:0] r1, input logic [4:0] r2);
      bus.fir_valid  = fv;
      bus.fir_waddr  = fa;
      bus.fir_wdata  = fd;
      bus.core_we    = cw;
      bus.core_rd    = cr;
      bus.core_wdata = cd;
      bus.rs1        = r1;
      bus.rs2        = r2;
   endtask

   task automatic add(input logic fv, input logic [4:0] fa, input logic [31:0] fd,
                      input logic cw, input logic [4:0] cr, input logic [31:0] cd,
                      input logic [4:0] r1, input logic [4:0] r2,
                      input logic rdy, input logic st, input logic hz, input logic we,
                      input logic [4:0] ad, input logic [31:0] dt, input logic [2:0] cn);
      vec_t v;
      v = '{fv, fa, fd, cw, cr, cd, r1, r2, rdy, st, hz, we, ad, dt, cn};
      vecs.push_back(v);
   endtask

   // Checks every output in the current cycle, then advances past the next edge.
   task automatic check_cycle(input string tag, input int idx,
                              input logic rdy, input logic st, input logic hz, input logic we,
                              input logic [4:0] ad, input logic [31:0] dt, input logic [2:0] cn);
      @(negedge clock);
      $display("%s %0d: rf_we=%0b waddr=%0d wdata=%0h cnt=%0d rdy=%0b stall=%0b haz=%0b",
               tag, idx, bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.fifo_count,
               bus.fir_ready, bus.core_stall, bus.raw_hazard);
      chk({tag, ".fir_ready"},  idx, 32'(bus.fir_ready),  32'(rdy));
      chk({tag, ".core_stall"}, idx, 32'(bus.core_stall), 32'(st));
      chk({tag, ".raw_hazard"}, idx, 32'(bus.raw_hazard), 32'(hz));
      chk({tag, ".rf_we"},      idx, 32'(bus.rf_we),      32'(we));
      chk({tag, ".rf_waddr"},   idx, 32'(bus.rf_waddr),   32'(ad));
      chk({tag, ".rf_wdata"},   idx, bus.rf_wdata,        dt);
      chk({tag, ".fifo_count"}, idx, 32'(bus.fifo_count), 32'(cn));
      @(posedge clock);
      #1;
   endtask

   initial begin
      //    fv fa  fd       cw cr cd      r1 r2   rdy st hz we ad dt       cnt
      add(0, 0,  0,       0, 0, 0,      0, 0,   1, 0, 0, 0, 0, 0,       0);
      add(1, 5,  100,     0, 0, 0,      0, 0,   1, 0, 0, 0, 0, 0,       0);
      add(0, 0,  0,       0, 0, 0,      0, 0,   1, 0, 0, 1, 5, 100,     1);
      add(0, 0,  0,       0, 0, 0,      0, 0,   1, 0, 0, 0, 0, 0,       0);
      add(1, 0,  55,      1, 0, 77,     0, 0,   1, 0, 0, 0, 0, 0,       0);
      add(0, 0,  0,       0, 0, 0,      0, 0,   1, 0, 0, 0, 0, 0,       0);
      add(1, 12, 'hC0,    1, 3, 'h33,   0, 0,   1, 0, 0, 1, 3, 'h33,    0);
      add(0, 0,  0,       1, 4, 'h44,   12, 0,  1, 0, 1, 1, 4, 'h44,    1);
      add(0, 0,  0,       0, 0, 0,      12, 0,  1, 0, 1, 1, 12, 'hC0,   1);
      add(0, 0,  0,       0, 0, 0,      12, 0,  1, 0, 0, 0, 0, 0,       0);
      add(1, 6,  'h66,    1, 1, 1,      0, 0,   1, 0, 0, 1, 1, 1,       0);
      add(0, 0,  0,       1, 2, 2,      0, 0,   1, 0, 0, 1, 2, 2,       1);
      add(0, 0,  0,       0, 0, 0,      0, 6,   1, 0, 1, 1, 6, 'h66,    1);
      add(0, 0,  0,       0, 0, 0,      0, 0,   1, 0, 0, 0, 0, 0,       0);
      add(1, 1,  'h1001,  1, 7, 'h701,  0, 0,   1, 0, 0, 1, 7, 'h701,   0);
      add(1, 2,  'h1002,  1, 7, 'h702,  0, 0,   1, 0, 0, 1, 7, 'h702,   1);
      add(1, 3,  'h1003,  1, 7, 'h703,  0, 0,   1, 0, 0, 1, 7, 'h703,   2);
      add(1, 4,  'h1004,  1, 7, 'h704,  0, 0,   1, 0, 0, 1, 7, 'h704,   3);
      add(1, 5,  'h1005,  1, 7, 'h705,  9, 8,   0, 0, 0, 1, 7, 'h705,   4);
      add(1, 5,  'h1005,  0, 0, 0,      0, 0,   0, 0, 0, 1, 1, 'h1001,  4);
      add(1, 5,  'h1005,  0, 0, 0,      0, 0,   1, 0, 0, 1, 2, 'h1002,  3);
      add(0, 0,  0,       0, 0, 0,      5, 0,   1, 0, 1, 1, 3, 'h1003,  3);
      add(0, 0,  0,       0, 0, 0,      0, 5,   1, 0, 1, 1, 4, 'h1004,  2);
      add(0, 0,  0,       0, 0, 0,      5, 0,   1, 0, 1, 1, 5, 'h1005,  1);
      add(0, 0,  0,       0, 0, 0,      5, 0,   1, 0, 0, 0, 0, 0,       0);

      drive(0, 0, 0, 0, 0, 0, 0, 0);
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;

      foreach (vecs[i]) begin
         drive(vecs[i].fv, vecs[i].fa, vecs[i].fd, vecs[i].cw, vecs[i].cr, vecs[i].cd,
               vecs[i].r1, vecs[i].r2);
         check_cycle("vec", i, vecs[i].e_rdy, vecs[i].e_stall, vecs[i].e_haz, vecs[i].e_we,
                     vecs[i].e_addr, vecs[i].e_data, vecs[i].e_cnt);
      end

      // Starvation: core writes x7 every cycle while FIR x9=42 waits.
      drive(1, 9, 42, 1, 7, 'h7A, 0, 0);
      check_cycle("starve_enq", 0, 1, 0, 0, 1, 7, 'h7A, 0);
      drive(0, 0, 0, 1, 7, 'h7A, 0, 0);
      for (int k = 0; k < MAX_WAIT; k++)
         check_cycle("starve_pend", k, 1, 0, 0, 1, 7, 'h7A, 1);
      check_cycle("starve_force", 0, 1, 1, 0, 1, 9, 42, 1);
      check_cycle("starve_retry", 0, 1, 0, 0, 1, 7, 'h7A, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      check_cycle("starve_idle", 0, 1, 0, 0, 0, 0, 0, 0);

      // Reset with three entries queued behind a busy core.
      drive(1, 10, 'hA0, 1, 7, 'h71, 0, 0);
      check_cycle("rst_fill", 0, 1, 0, 0, 1, 7, 'h71, 0);
      drive(1, 11, 'hB0, 1, 7, 'h72, 0, 0);
      check_cycle("rst_fill", 1, 1, 0, 0, 1, 7, 'h72, 1);
      drive(1, 12, 'hC0, 1, 7, 'h73, 0, 0);
      check_cycle("rst_fill", 2, 1, 0, 0, 1, 7, 'h73, 2);
      drive(0, 0, 0, 1, 7, 'h74, 10, 0);
      reset = 1'b1;
      check_cycle("rst_hold", 0, 1, 0, 1, 1, 7, 'h74, 3);
      reset = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 10, 11);
      check_cycle("rst_after", 0, 1, 0, 0, 0, 0, 0, 0);
      check_cycle("rst_after", 1, 1, 0, 0, 0, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Arbitrates the register file's single write port between core writeback and the FIR accelerator. FIR writes are queued in a small FIFO instead of silently displacing core writes. Core writeback has priority, and an age counter bounds how long FIR can be starved. The block sits between the writeback stage, the FIR engine and the register file, and reports read-after-write hazards on queued FIR destinations.

## Interface
- DEPTH, 4: FIR write FIFO entries (power of two, ≥2)
- MAX_WAIT, 8: cycles a non-empty FIFO head may wait before a forced grant (≥1)
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- fir_valid  in  1  FIR write request
- fir_ready  out  1  FIFO can accept (count < DEPTH)
- fir_waddr  in  5  FIR destination register
- fir_wdata  in  32  FIR write data
- core_we  in  1  core writeback enable
- core_rd  in  5  core destination register
- core_wdata  in  32  core write data
- core_stall  out  1  core must hold writeback this cycle
- rs1, rs2  in  5 each  decode-stage source registers
- raw_hazard  out  1  a queued FIR entry targets non-zero rs1/rs2
- rf_we  out  1  register-file write enable
- rf_waddr  out  5  register-file write address
- rf_wdata  out  32  register-file write data
- fifo_count  out  clog2(DEPTH)+1  valid FIFO entries

## Operation
- Enqueue occurs when fir_valid && fir_ready at a clock edge. fir_waddr==0 is accepted but not queued.
- States:
  - EMPTY: FIFO empty.
  - PEND: non-empty, core has priority.
  - FORCE: FIR head granted, core stalled.
- Transitions:
  - EMPTY→PEND on enqueue.
  - PEND→FORCE when wait_cnt reaches MAX_WAIT.
  - PEND→EMPTY when the last entry dequeues with no enqueue.
  - FORCE→PEND or EMPTY after one cycle, depending on the resulting count.
- Grant in EMPTY or PEND:
  - If core_we && core_rd!=0: rf_* = core inputs, FIFO holds.
  - Otherwise, if FIFO is non-empty: rf_* = FIFO head, and the head dequeues at the edge.
  - Otherwise: rf_we=0.
- Grant in FORCE: rf_* = FIFO head, head dequeues, core_stall=1, and core inputs are ignored. The core holds them and presents them again next cycle.
- wait_cnt:
  - Cleared on every dequeue and whenever the FIFO is empty.
  - Otherwise increments once per cycle, saturating at MAX_WAIT.
- raw_hazard is combinational: OR over valid entries of (addr==rs1 && rs1!=0) || (addr==rs2 && rs2!=0).
- Core writes with core_rd==0 never drive rf_we.
- With core_stall=1, enqueue still proceeds if fir_ready.

## Timing
- Reset values: state=EMPTY, count=0, wait_cnt=0, fir_ready=1, core_stall=0, raw_hazard=0, rf_we=0, rf_waddr=0, rf_wdata=0.
- rf_* and core_stall are combinational from registered state and core inputs. A core write commits at the same edge as without the arbiter.
- FIR latency: an entry accepted at edge N can commit at edge N+1 at the earliest. There is no enqueue-to-port bypass.
- Worst-case FIR head wait is MAX_WAIT cycles plus the single FORCE cycle.
- Full FIFO: fir_ready=0 even if a dequeue occurs in the same cycle. A freed slot is visible the next cycle.
- Simultaneous enqueue and dequeue: count is unchanged.
- Pointers wrap modulo DEPTH.
- Reset mid-operation: FIFO is flushed and queued writes are discarded. The next cycle is EMPTY.

## Structure
- Shared package `rf_arb_pkg`:
  - state encoding (EMPTY/PEND/FORCE)
  - FIR entry typedef {addr[4:0], data[31:0]}
  - REG_ADDR_W=5, XLEN=32
- Sub-module `rf_wr_fifo`: synchronous FIFO with count output and per-entry address taps for the hazard compare.
- The arbiter FSM, wait counter and output mux live in the top module.

## Test plan
- Idle core: FIR writes x5=100 at cycle 2 → rf_we=1, waddr=5, wdata=100 at cycle 3; fifo_count 1→0.
- Continuous core_we to x7 with FIR x9=42 queued, MAX_WAIT=8 → exactly one FORCE cycle after 8 PEND cycles: core_stall=1 and rf write x9=42 in that cycle. The held core x7 write commits the next cycle.
- Fill 4 entries while the core writes every cycle → fir_ready=0 and fifo_count=4. A fifth request is not accepted until after a dequeue.
- FIR x0 write and core rd=0 write → rf_we stays 0 and fifo_count stays 0.
- Queued FIR x12, rs1=12 → raw_hazard=1. It clears the cycle after x12 commits. rs2=0 with an x0-only compare never asserts raw_hazard.
- Assert reset with 3 entries queued → the next cycle shows fifo_count=0, rf_we=0, fir_ready=1, core_stall=0.
